// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit.
//   md_op_e : E-stage MDU opcode (same encoding as the decoder emits)
//   state_e : sequencer FSM states
//   MULT_CYCLES_DEF / DIV_CYCLES_DEF : default fixed latencies
//   is_long_op : true for opcodes that occupy the unit for several cycles
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath.
//   op     : MDU opcode (mdu_pkg::md_op_e encoding)
//   rs, rt : operands (rs = multiplicand / dividend, rt = multiplier / divisor)
//   res_hi : product[2W-1:W] or remainder
//   res_lo : product[W-1:0]  or quotient
// Division by zero yields lo = all-ones, hi = dividend. Signed MIN / -1
// yields lo = MIN, hi = 0. Non-multiply/divide opcodes produce zero.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  // Operands widened to the full product width so the multiply is exact.
  logic signed [2*WIDTH-1:0] rs_sx, rt_sx, prod_s;
  logic        [2*WIDTH-1:0] rs_zx, rt_zx, prod_u;

  assign rs_sx  = {{WIDTH{rs[WIDTH-1]}}, rs};
  assign rt_sx  = {{WIDTH{rt[WIDTH-1]}}, rt};
  assign prod_s = rs_sx * rt_sx;
  assign rs_zx  = {{WIDTH{1'b0}}, rs};
  assign rt_zx  = {{WIDTH{1'b0}}, rt};
  assign prod_u = rs_zx * rt_zx;

  logic div_zero, div_ovf;
  assign div_zero = (rt == '0);
  assign div_ovf  = (rs == MIN_NEG) && (rt == ALL_ONES);

  // The divider never sees a zero or overflowing divisor; those cases are
  // substituted after the fact, so the raw quotient is always well-defined.
  logic        [WIDTH-1:0] rt_safe;
  logic signed [WIDTH-1:0] rs_s, rt_s, quot_s, rem_s;
  logic        [WIDTH-1:0] quot_u, rem_u;

  assign rt_safe = (div_zero || div_ovf) ? ONE : rt;
  assign rs_s    = rs;
  assign rt_s    = rt_safe;
  assign quot_s  = rs_s / rt_s;
  assign rem_s   = rs_s % rt_s;
  assign quot_u  = rs / rt_safe;
  assign rem_u   = rs % rt_safe;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: begin
        if (div_zero) begin
          res_hi = rs;
          res_lo = ALL_ONES;
        end else if (div_ovf) begin
          res_hi = '0;
          res_lo = MIN_NEG;
        end else begin
          res_hi = rem_s;
          res_lo = quot_s;
        end
      end
      MD_DIVU: begin
        if (div_zero) begin
          res_hi = rs;
          res_lo = ALL_ONES;
        end else begin
          res_hi = rem_u;
          res_lo = quot_u;
        end
      end
      default: begin
        res_hi = '0;
        res_lo = '0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer; owns HI/LO for the E stage.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   E_start    : valid MDU instruction in E this cycle
//   E_mdop     : MDU opcode (mdu_pkg::md_op_e)
//   E_rs_val   : forwarded rs operand
//   E_rt_val   : forwarded rt operand
//   D_is_md    : D-stage instruction touches the MDU / HI / LO
//   busy       : computation in flight (registered)
//   md_stall   : stall request for the D/E pipeline registers (combinational)
//   hi, lo     : architectural HI / LO registers
// Results are computed at start into pending registers and only committed to
// HI/LO on the edge that ends the busy window, emulating a fixed latency.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             E_start,
  input  logic [2:0]       E_mdop,
  input  logic [WIDTH-1:0] E_rs_val,
  input  logic [WIDTH-1:0] E_rt_val,
  input  logic             D_is_md,
  output logic             busy,
  output logic             md_stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  state_e           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] pend_hi, pend_lo;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             long_op, mul_op;

  assign long_op = is_long_op(E_mdop);
  assign mul_op  = (E_mdop == MD_MULT) || (E_mdop == MD_MULTU);

  mdu_arith #(
    .WIDTH (WIDTH)
  ) u_arith (
    .op     (E_mdop),
    .rs     (E_rs_val),
    .rt     (E_rt_val),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  // A long op sitting in E stalls D even before busy rises; mthi/mtlo do not.
  assign md_stall = D_is_md & (busy | (E_start & long_op));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      count   <= '0;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (E_start) begin
            if (long_op) begin
              pend_hi <= res_hi;
              pend_lo <= res_lo;
              count   <= mul_op ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
              busy    <= 1'b1;
              state   <= ST_RUN;
            end else if (E_mdop == MD_MTHI) begin
              hi <= E_rs_val;
            end else if (E_mdop == MD_MTLO) begin
              lo <= E_rs_val;
            end
          end
        end
        ST_RUN: begin
          // Any E_start here is ignored; the hazard unit is expected to hold it off.
          if (count == CW'(1)) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            busy  <= 1'b0;
            count <= '0;
            state <= ST_IDLE;
          end else begin
            count <= count - CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          count <= '0;
        end
      endcase
    end
  end

endmodule
